// File: rtl/crc_pkg.sv
// Shared definitions for the channel cycle scheduler: requester indices, phase encoding, defaults.
package crc_pkg;

  localparam int NREQ       = 5;
  localparam int STARVE_LIM = 4;

  // Requester index doubles as fixed priority, 0 highest
  localparam int REQ_MST   = 0;
  localparam int REQ_CCWF  = 1;
  localparam int REQ_ACT   = 2;
  localparam int REQ_CONTR = 3;
  localparam int REQ_CBUS  = 4;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_T0   = 3'd1,
    PH_T1   = 3'd2,
    PH_T2   = 3'd3,
    PH_T3   = 3'd4
  } phase_e;

endpackage

// File: rtl/crc_cyc_sched_if.sv
// Request / cycle-strobe bundle between the channel requesters and the cycle scheduler.
interface crc_cyc_sched_if;
  import crc_pkg::*;

  logic            ccl_mem_store_req_h;
  logic            ccw_ccwf_req_h;
  logic            ccl_act_flag_req_h;
  logic            ch_contr_req_h;
  logic            ch_cbus_req_h;
  logic            ch_reset_intr_h;
  logic [NREQ-1:0] crc_grant_h;
  logic [1:0]      crc_phase_h;
  logic            crc_busy_h;
  logic            crc_done_h;
  logic            crc_ram_cyc_h;
  logic            crc_mb_cyc_h;
  logic            crc_cbus_contr_cyc_h;
  logic [2:0]      crc_act_ctr_h;

  modport master (
    output ccl_mem_store_req_h, ccw_ccwf_req_h, ccl_act_flag_req_h,
           ch_contr_req_h, ch_cbus_req_h, ch_reset_intr_h,
    input  crc_grant_h, crc_phase_h, crc_busy_h, crc_done_h,
           crc_ram_cyc_h, crc_mb_cyc_h, crc_cbus_contr_cyc_h, crc_act_ctr_h
  );

  modport slave (
    input  ccl_mem_store_req_h, ccw_ccwf_req_h, ccl_act_flag_req_h,
           ch_contr_req_h, ch_cbus_req_h, ch_reset_intr_h,
    output crc_grant_h, crc_phase_h, crc_busy_h, crc_done_h,
           crc_ram_cyc_h, crc_mb_cyc_h, crc_cbus_contr_cyc_h, crc_act_ctr_h
  );

endinterface

// File: rtl/crc_prio_pick.sv
// Combinational one-hot picker: lowest-index starved request wins, else lowest-index request.
// Zero latency; no backpressure, vld simply follows any active request.
module crc_prio_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] starved,
  output logic [N-1:0] win,
  output logic         vld
);

  logic [N-1:0] hungry;
  logic [N-1:0] cand;
  logic         found;

  always_comb begin
    hungry = req & starved;
    cand   = (|hungry) ? hungry : req;
    win    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    vld = |req;
  end

endmodule

// File: rtl/crc_cyc_sched.sv
// Channel RAM/MB cycle scheduler: arbitrates five requesters, runs a fixed 4-clock T0..T3 cycle per grant.
// Requesters are held off (no grant) until IDLE or T3; back-to-back cycles when a request is waiting at T3.
module crc_cyc_sched
  import crc_pkg::*;
(
  input  logic            clk_crc_h,
  input  logic            ch_mr_reset_l,
  crc_cyc_sched_if.slave  bus
);

  localparam logic [2:0] S_IDLE = PH_IDLE;
  localparam logic [2:0] S_T0   = PH_T0;
  localparam logic [2:0] S_T1   = PH_T1;
  localparam logic [2:0] S_T2   = PH_T2;
  localparam logic [2:0] S_T3   = PH_T3;
  localparam logic [2:0] LIM    = 3'(STARVE_LIM);

  logic [2:0]      state_q;
  logic [2:0]      state_nxt;
  logic [NREQ-1:0] grant_q;
  logic [2:0]      starve_q [NREQ];
  logic [2:0]      act_q;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] win;
  logic            win_vld;
  logic            arb_slot;
  logic            abort;

  always_comb begin
    req            = '0;
    req[REQ_MST]   = bus.ccl_mem_store_req_h;
    req[REQ_CCWF]  = bus.ccw_ccwf_req_h;
    req[REQ_ACT]   = bus.ccl_act_flag_req_h;
    req[REQ_CONTR] = bus.ch_contr_req_h;
    req[REQ_CBUS]  = bus.ch_cbus_req_h;
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < NREQ; i++) starved[i] = (starve_q[i] == LIM);
  end

  crc_prio_pick #(.N(NREQ)) u_pick (
    .req     (req),
    .starved (starved),
    .win     (win),
    .vld     (win_vld)
  );

  assign abort    = bus.ch_reset_intr_h;
  assign arb_slot = (state_q == S_IDLE) || (state_q == S_T3);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_T3: state_nxt = win_vld ? S_T0 : S_IDLE;
      S_T0:         state_nxt = S_T1;
      S_T1:         state_nxt = S_T2;
      S_T2:         state_nxt = S_T3;
      default:      state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_crc_h or negedge ch_mr_reset_l) begin
    if (!ch_mr_reset_l) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < NREQ; i++) starve_q[i] <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < NREQ; i++) starve_q[i] <= '0;
    end else begin
      state_q <= state_nxt;
      if (arb_slot) begin
        grant_q <= win_vld ? win : '0;
        // Losers age toward promotion; winners and idle requesters start over
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && !win[i])
            starve_q[i] <= (starve_q[i] < LIM) ? starve_q[i] + 3'd1 : starve_q[i];
          else
            starve_q[i] <= '0;
        end
      end
      if (state_q == S_T3) begin
        if (grant_q[REQ_CCWF])
          act_q <= '0;
        else if (grant_q[REQ_ACT])
          act_q <= act_q + 3'd1;
      end
    end
  end

  // Outputs decode from registered state and grant only
  always_comb begin
    case (state_q)
      S_T1:    bus.crc_phase_h = 2'd1;
      S_T2:    bus.crc_phase_h = 2'd2;
      S_T3:    bus.crc_phase_h = 2'd3;
      default: bus.crc_phase_h = 2'd0;
    endcase
  end

  assign bus.crc_grant_h          = grant_q;
  assign bus.crc_busy_h           = (state_q != S_IDLE);
  assign bus.crc_done_h           = (state_q == S_T3);
  assign bus.crc_ram_cyc_h        = (state_q == S_T1) && (|grant_q[REQ_CONTR:REQ_MST]);
  assign bus.crc_mb_cyc_h         = ((state_q == S_T2) || (state_q == S_T3)) && grant_q[REQ_MST];
  assign bus.crc_cbus_contr_cyc_h = (state_q != S_IDLE) && grant_q[REQ_CBUS];
  assign bus.crc_act_ctr_h        = act_q;

endmodule

// File: tb/tb_crc_cyc_sched.sv
// Directed bench for crc_cyc_sched: reset, single grant, starvation, act counter, abort, async reset, early drop.
module tb_crc_cyc_sched;
  import crc_pkg::*;

  logic clk_crc_h;
  logic ch_mr_reset_l;
  int   total = 0;
  int   bad   = 0;
  logic mb_seen;

  crc_cyc_sched_if bus ();

  crc_cyc_sched dut (
    .clk_crc_h     (clk_crc_h),
    .ch_mr_reset_l (ch_mr_reset_l),
    .bus           (bus)
  );

  initial clk_crc_h = 1'b0;
  always #5 clk_crc_h = ~clk_crc_h;

  always @(negedge clk_crc_h) if (bus.crc_mb_cyc_h === 1'b1) mb_seen = 1'b1;

  task automatic tick();
    @(posedge clk_crc_h);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mb_seen                 = 1'b0;
    ch_mr_reset_l           = 1'b0;
    bus.ccl_mem_store_req_h = 1'b0;
    bus.ccw_ccwf_req_h      = 1'b0;
    bus.ccl_act_flag_req_h  = 1'b0;
    bus.ch_contr_req_h      = 1'b0;
    bus.ch_cbus_req_h       = 1'b0;
    bus.ch_reset_intr_h     = 1'b0;

    // Reset state
    #2;
    chk("rst_grant", 32'(bus.crc_grant_h), 32'h0);
    chk("rst_busy", 32'(bus.crc_busy_h), 32'h0);
    chk("rst_phase", 32'(bus.crc_phase_h), 32'h0);
    chk("rst_act", 32'(bus.crc_act_ctr_h), 32'h0);
    #10 ch_mr_reset_l = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.crc_busy_h), 32'h0);

    // Single idx3 request
    bus.ch_contr_req_h = 1'b1;
    tick();
    chk("c3_t0_grant", 32'(bus.crc_grant_h), 32'h08);
    chk("c3_t0_phase", 32'(bus.crc_phase_h), 32'h0);
    chk("c3_t0_ram", 32'(bus.crc_ram_cyc_h), 32'h0);
    tick();
    chk("c3_t1_ram", 32'(bus.crc_ram_cyc_h), 32'h1);
    chk("c3_t1_phase", 32'(bus.crc_phase_h), 32'h1);
    tick();
    chk("c3_t2_ram", 32'(bus.crc_ram_cyc_h), 32'h0);
    chk("c3_t2_grant", 32'(bus.crc_grant_h), 32'h08);
    tick();
    chk("c3_t3_done", 32'(bus.crc_done_h), 32'h1);
    chk("c3_t3_phase", 32'(bus.crc_phase_h), 32'h3);
    bus.ch_contr_req_h = 1'b0;
    tick();
    chk("c3_idle_busy", 32'(bus.crc_busy_h), 32'h0);
    chk("c3_idle_grant", 32'(bus.crc_grant_h), 32'h0);
    chk("c3_idle_done", 32'(bus.crc_done_h), 32'h0);

    // idx0 and idx4 held: idx0 wins four times, then idx4 is promoted
    bus.ccl_mem_store_req_h = 1'b1;
    bus.ch_cbus_req_h       = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("st_grant0", 32'(bus.crc_grant_h), 32'h01);
      chk("st_busy", 32'(bus.crc_busy_h), 32'h1);
      chk("st_starve4", 32'(dut.starve_q[REQ_CBUS]), 32'(c));
      tick(); tick(); tick();
      chk("st_done", 32'(bus.crc_done_h), 32'h1);
      chk("st_mb_t3", 32'(bus.crc_mb_cyc_h), 32'h1);
      if (c == 4) bus.ccl_mem_store_req_h = 1'b0;
      tick();
    end
    chk("st_grant4", 32'(bus.crc_grant_h), 32'h10);
    chk("st_nogap_phase", 32'(bus.crc_phase_h), 32'h0);
    chk("st_cbus_cyc", 32'(bus.crc_cbus_contr_cyc_h), 32'h1);
    chk("st_ram_t0", 32'(bus.crc_ram_cyc_h), 32'h0);
    tick();
    chk("st_ram_cbus_t1", 32'(bus.crc_ram_cyc_h), 32'h0);
    tick(); tick();
    bus.ch_cbus_req_h = 1'b0;
    tick();
    chk("st_idle", 32'(bus.crc_busy_h), 32'h0);

    // idx2 granted nine times back-to-back: act ctr 1..7,0,1
    bus.ccl_act_flag_req_h = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      tick(); tick(); tick();
      chk("act_done", 32'(bus.crc_done_h), 32'h1);
      if (k == 9) bus.ccl_act_flag_req_h = 1'b0;
      tick();
      chk("act_ctr", 32'(bus.crc_act_ctr_h), 32'(k % 8));
    end
    chk("act_idle", 32'(bus.crc_busy_h), 32'h0);
    bus.ccw_ccwf_req_h = 1'b1;
    tick();
    chk("ccwf_grant", 32'(bus.crc_grant_h), 32'h02);
    tick(); tick(); tick();
    chk("ccwf_t3_act", 32'(bus.crc_act_ctr_h), 32'h1);
    bus.ccw_ccwf_req_h = 1'b0;
    tick();
    chk("ccwf_act_clr", 32'(bus.crc_act_ctr_h), 32'h0);

    // Abort in T1 of an idx0 grant, with act ctr preloaded to 1
    bus.ccl_act_flag_req_h = 1'b1;
    tick(); tick(); tick(); tick();
    bus.ccl_act_flag_req_h = 1'b0;
    tick();
    chk("ab_pre_act", 32'(bus.crc_act_ctr_h), 32'h1);
    mb_seen = 1'b0;
    bus.ccl_mem_store_req_h = 1'b1;
    tick(); tick();
    chk("ab_t1_ram", 32'(bus.crc_ram_cyc_h), 32'h1);
    bus.ch_reset_intr_h = 1'b1;
    tick();
    chk("ab_busy", 32'(bus.crc_busy_h), 32'h0);
    chk("ab_done", 32'(bus.crc_done_h), 32'h0);
    chk("ab_grant", 32'(bus.crc_grant_h), 32'h0);
    chk("ab_act", 32'(bus.crc_act_ctr_h), 32'h0);
    bus.ch_reset_intr_h     = 1'b0;
    bus.ccl_mem_store_req_h = 1'b0;
    tick();
    chk("ab_stay_idle", 32'(bus.crc_busy_h), 32'h0);
    chk("ab_mb_never", 32'(mb_seen), 32'h0);

    // Master reset mid-T2 of an idx0 cycle
    bus.ccl_mem_store_req_h = 1'b1;
    tick(); tick(); tick();
    chk("mr_t2_mb", 32'(bus.crc_mb_cyc_h), 32'h1);
    #2 ch_mr_reset_l = 1'b0;
    #1;
    chk("mr_grant", 32'(bus.crc_grant_h), 32'h0);
    chk("mr_busy", 32'(bus.crc_busy_h), 32'h0);
    chk("mr_mb", 32'(bus.crc_mb_cyc_h), 32'h0);
    chk("mr_phase", 32'(bus.crc_phase_h), 32'h0);
    bus.ccl_mem_store_req_h = 1'b0;
    bus.ch_cbus_req_h       = 1'b1;
    #2 ch_mr_reset_l = 1'b1;
    tick();
    chk("mr_rel_grant", 32'(bus.crc_grant_h), 32'h10);
    for (int n = 0; n < 4; n++) begin
      chk("mr_cbus_cyc", 32'(bus.crc_cbus_contr_cyc_h), 32'h1);
      if (n == 3) bus.ch_cbus_req_h = 1'b0;
      tick();
    end
    chk("mr_cbus_off", 32'(bus.crc_cbus_contr_cyc_h), 32'h0);

    // idx1 request dropped in T1: cycle still completes
    bus.ccw_ccwf_req_h = 1'b1;
    tick(); tick();
    bus.ccw_ccwf_req_h = 1'b0;
    tick();
    chk("drop_t2_busy", 32'(bus.crc_busy_h), 32'h1);
    tick();
    chk("drop_t3_done", 32'(bus.crc_done_h), 32'h1);
    chk("drop_t3_grant", 32'(bus.crc_grant_h), 32'h02);
    tick();
    chk("drop_idle", 32'(bus.crc_busy_h), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
